// File: rtl/ddr2_grant_seq.sv
// Grant sequencer for the DDR2 port: latches the priority encoder's winner, drives its
// command to the memory controller, acks the client on completion, then re-arms the encoder.
module ddr2_grant_seq #(
  parameter int ADDR_W = 25,
  parameter int DATA_W = 64
) (
  input  logic                clk,
  input  logic                rst,
  output logic                pe_en,
  input  logic [4:0]          pe_grant,
  input  logic [4:0]          cli_we,
  input  logic [5*ADDR_W-1:0] cli_addr,
  input  logic [5*DATA_W-1:0] cli_wdata,
  output logic [4:0]          cli_ack,
  output logic [DATA_W-1:0]   cli_rdata,
  output logic                mc_cmd_valid,
  input  logic                mc_cmd_ready,
  output logic                mc_we,
  output logic [ADDR_W-1:0]   mc_addr,
  output logic [DATA_W-1:0]   mc_wdata,
  input  logic                mc_done,
  input  logic [DATA_W-1:0]   mc_rdata,
  output logic                err_multi
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT    = 2'd2,
    S_RELEASE = 2'd3
  } state_e;

  function automatic logic [4:0] lowest_bit(input logic [4:0] v);
    return v & (~v + 5'd1);
  endfunction

  function automatic logic multi_bit(input logic [4:0] v);
    return (v & (v - 5'd1)) != 5'd0;
  endfunction

  function automatic logic [2:0] onehot_idx(input logic [4:0] oh);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 5; i++) begin
      idx = idx | (oh[i] ? 3'(i) : 3'd0);
    end
    return idx;
  endfunction

  state_e              state_q, state_d;
  logic [4:0]          gnt_q, gnt_d;
  logic                pe_en_q, pe_en_d;
  logic                mc_cmd_valid_q, mc_cmd_valid_d;
  logic                mc_we_q, mc_we_d;
  logic [ADDR_W-1:0]   mc_addr_q, mc_addr_d;
  logic [DATA_W-1:0]   mc_wdata_q, mc_wdata_d;
  logic [4:0]          cli_ack_q, cli_ack_d;
  logic [DATA_W-1:0]   cli_rdata_q, cli_rdata_d;
  logic                err_multi_q, err_multi_d;
  logic [4:0]          win_gnt_s;
  logic [2:0]          win_idx_s;

  // A malformed multi-bit grant is resolved toward the highest-priority (lowest) bit.
  assign win_gnt_s = lowest_bit(pe_grant);
  assign win_idx_s = onehot_idx(win_gnt_s);

  // Next-state and next-output logic for the grant sequencer.
  always_comb begin
    state_d        = state_q;
    gnt_d          = gnt_q;
    mc_cmd_valid_d = mc_cmd_valid_q;
    mc_we_d        = mc_we_q;
    mc_addr_d      = mc_addr_q;
    mc_wdata_d     = mc_wdata_q;
    cli_ack_d      = 5'd0;
    cli_rdata_d    = cli_rdata_q;
    err_multi_d    = err_multi_q;
    case (state_q)
      S_IDLE: begin
        if (pe_grant != 5'd0) begin
          gnt_d          = win_gnt_s;
          mc_we_d        = cli_we[win_idx_s];
          mc_addr_d      = cli_addr[win_idx_s*ADDR_W +: ADDR_W];
          mc_wdata_d     = cli_wdata[win_idx_s*DATA_W +: DATA_W];
          mc_cmd_valid_d = 1'b1;
          err_multi_d    = err_multi_q | multi_bit(pe_grant);
          state_d        = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        // mc_done here is deliberately ignored, even when it coincides with the accept.
        if (mc_cmd_valid_q && mc_cmd_ready) begin
          mc_cmd_valid_d = 1'b0;
          state_d        = S_WAIT;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_WAIT: begin
        if (mc_done) begin
          cli_rdata_d = mc_rdata;
          cli_ack_d   = gnt_q;
          state_d     = S_RELEASE;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_RELEASE: begin
        state_d = S_IDLE;
      end
      default: begin
        mc_cmd_valid_d = 1'b0;
        state_d        = S_IDLE;
      end
    endcase
  end

  // Encoder enable tracks the state being entered, so it is high exactly while in IDLE.
  assign pe_en_d = (state_d == S_IDLE);

  // State and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      gnt_q          <= 5'd0;
      pe_en_q        <= 1'b0;
      mc_cmd_valid_q <= 1'b0;
      mc_we_q        <= 1'b0;
      mc_addr_q      <= {ADDR_W{1'b0}};
      mc_wdata_q     <= {DATA_W{1'b0}};
      cli_ack_q      <= 5'd0;
      cli_rdata_q    <= {DATA_W{1'b0}};
      err_multi_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      gnt_q          <= gnt_d;
      pe_en_q        <= pe_en_d;
      mc_cmd_valid_q <= mc_cmd_valid_d;
      mc_we_q        <= mc_we_d;
      mc_addr_q      <= mc_addr_d;
      mc_wdata_q     <= mc_wdata_d;
      cli_ack_q      <= cli_ack_d;
      cli_rdata_q    <= cli_rdata_d;
      err_multi_q    <= err_multi_d;
    end
  end

  assign pe_en        = pe_en_q;
  assign mc_cmd_valid = mc_cmd_valid_q;
  assign mc_we        = mc_we_q;
  assign mc_addr      = mc_addr_q;
  assign mc_wdata     = mc_wdata_q;
  assign cli_ack      = cli_ack_q;
  assign cli_rdata    = cli_rdata_q;
  assign err_multi    = err_multi_q;

endmodule

// File: tb/tb_ddr2_grant_seq.sv
// Self-checking bench for ddr2_grant_seq: directed scenarios plus randomized transactions
// checked against a transaction-level model of grant selection, latency and error flagging.
module tb_ddr2_grant_seq;
  localparam int ADDR_W = 25;
  localparam int DATA_W = 64;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                pe_en;
  logic [4:0]          pe_grant = 5'd0;
  logic [4:0]          cli_we = 5'd0;
  logic [5*ADDR_W-1:0] cli_addr;
  logic [5*DATA_W-1:0] cli_wdata;
  logic [4:0]          cli_ack;
  logic [DATA_W-1:0]   cli_rdata;
  logic                mc_cmd_valid;
  logic                mc_cmd_ready = 1'b0;
  logic                mc_we;
  logic [ADDR_W-1:0]   mc_addr;
  logic [DATA_W-1:0]   mc_wdata;
  logic                mc_done = 1'b0;
  logic [DATA_W-1:0]   mc_rdata = 64'd0;
  logic                err_multi;

  logic [ADDR_W-1:0] addr_a [5];
  logic [DATA_W-1:0] wdata_a [5];

  int n_cmp = 0;
  int n_bad = 0;
  bit err_model = 1'b0;

  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    bit                hold_ok;
    bit                valid_drop;
    logic [4:0]        early_ack;
    logic [4:0]        ack;
    logic [4:0]        ack_after;
    logic [DATA_W-1:0] rdata;
    logic              pe_en_m1;
    logic              pe_en_m2;
    logic              err;
    int                wait_cycles;
    bit                timeout;
  } obs_t;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < 5; i++) begin
      cli_addr[i*ADDR_W +: ADDR_W]  = addr_a[i];
      cli_wdata[i*DATA_W +: DATA_W] = wdata_a[i];
    end
  end

  ddr2_grant_seq #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .pe_en(pe_en), .pe_grant(pe_grant), .cli_we(cli_we),
    .cli_addr(cli_addr), .cli_wdata(cli_wdata), .cli_ack(cli_ack), .cli_rdata(cli_rdata),
    .mc_cmd_valid(mc_cmd_valid), .mc_cmd_ready(mc_cmd_ready), .mc_we(mc_we),
    .mc_addr(mc_addr), .mc_wdata(mc_wdata), .mc_done(mc_done), .mc_rdata(mc_rdata),
    .err_multi(err_multi)
  );

  // Reference: the served client is the highest-priority (lowest-index) set bit.
  function automatic int model_winner(input logic [4:0] g);
    for (int i = 0; i < 5; i++) begin
      if (g[i]) return i;
    end
    return 0;
  endfunction

  task automatic scramble_clients();
    for (int i = 0; i < 5; i++) begin
      addr_a[i]  = ADDR_W'($urandom);
      wdata_a[i] = {$urandom, $urandom};
    end
    cli_we = 5'($urandom);
  endtask

  // Plays encoder and controller for one transaction and records what the DUT did.
  task automatic run_txn(input logic [4:0] g, input int rdy_dly, input int done_dly,
                         input logic [DATA_W-1:0] rd, input bit perturb, input bit done_in_issue,
                         output obs_t o);
    o.wait_cycles = 0;
    o.timeout     = 1'b0;
    o.early_ack   = 5'd0;
    while (pe_en !== 1'b1 && o.wait_cycles < 8) begin
      @(negedge clk);
      o.wait_cycles++;
    end
    if (pe_en !== 1'b1) o.timeout = 1'b1;
    pe_grant = g;
    @(negedge clk);
    pe_grant  = 5'd0;
    o.we      = mc_we;
    o.addr    = mc_addr;
    o.wdata   = mc_wdata;
    o.hold_ok = (mc_cmd_valid === 1'b1) && (pe_en === 1'b0);
    for (int k = 0; k < rdy_dly; k++) begin
      if (perturb) scramble_clients();
      @(negedge clk);
      if (mc_cmd_valid !== 1'b1 || mc_we !== o.we || mc_addr !== o.addr || mc_wdata !== o.wdata)
        o.hold_ok = 1'b0;
      o.early_ack |= cli_ack;
    end
    mc_cmd_ready = 1'b1;
    mc_done      = done_in_issue;
    mc_rdata     = ~rd;
    @(negedge clk);
    mc_cmd_ready = 1'b0;
    mc_done      = 1'b0;
    o.valid_drop = (mc_cmd_valid === 1'b0);
    o.early_ack |= cli_ack;
    for (int k = 0; k < done_dly; k++) begin
      @(negedge clk);
      o.early_ack |= cli_ack;
    end
    mc_done  = 1'b1;
    mc_rdata = rd;
    @(negedge clk);
    mc_done    = 1'b0;
    mc_rdata   = {$urandom, $urandom};
    o.ack      = cli_ack;
    o.rdata    = cli_rdata;
    o.pe_en_m1 = pe_en;
    @(negedge clk);
    o.ack_after = cli_ack;
    o.pe_en_m2  = pe_en;
    o.err       = err_multi;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (pe_en !== 1'b0) begin n_bad++; $display("FAIL rst_pe_en: got %b want 0", pe_en); end
    n_cmp++; if (mc_cmd_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", mc_cmd_valid); end
    n_cmp++; if (cli_ack !== 5'd0) begin n_bad++; $display("FAIL rst_ack: got %b want 00000", cli_ack); end
    n_cmp++; if (err_multi !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %b want 0", err_multi); end
    n_cmp++; if (mc_addr !== 25'd0 || mc_we !== 1'b0 || mc_wdata !== 64'd0 || cli_rdata !== 64'd0) begin
      n_bad++; $display("FAIL rst_data: got addr %h we %b wdata %h rdata %h want zeros", mc_addr, mc_we, mc_wdata, cli_rdata);
    end
    rst = 1'b0;
    err_model = 1'b0;
    @(negedge clk);
    n_cmp++; if (pe_en !== 1'b1) begin n_bad++; $display("FAIL rst_release_pe_en: got %b want 1", pe_en); end
  endtask

  task automatic test_single_read();
    obs_t o;
    addr_a[2] = 25'h0ABCDE;
    cli_we    = 5'b11011;
    run_txn(5'b00100, 0, 3, 64'hDEADBEEF_01234567, 1'b0, 1'b0, o);
    n_cmp++; if (o.timeout) begin n_bad++; $display("FAIL t2_timeout: got timeout want pe_en=1"); end
    n_cmp++; if (o.addr !== 25'h0ABCDE) begin n_bad++; $display("FAIL t2_addr: got %h want 0abcde", o.addr); end
    n_cmp++; if (o.we !== 1'b0) begin n_bad++; $display("FAIL t2_we: got %b want 0", o.we); end
    n_cmp++; if (!o.hold_ok || !o.valid_drop) begin n_bad++; $display("FAIL t2_valid: got issue %b drop %b want 1 1", o.hold_ok, o.valid_drop); end
    n_cmp++; if (o.early_ack !== 5'd0) begin n_bad++; $display("FAIL t2_early_ack: got %b want 00000", o.early_ack); end
    n_cmp++; if (o.ack !== 5'b00100) begin n_bad++; $display("FAIL t2_ack: got %b want 00100", o.ack); end
    n_cmp++; if (o.ack_after !== 5'd0) begin n_bad++; $display("FAIL t2_ack_width: got %b want 00000", o.ack_after); end
    n_cmp++; if (o.rdata !== 64'hDEADBEEF_01234567) begin n_bad++; $display("FAIL t2_rdata: got %h want deadbeef01234567", o.rdata); end
    n_cmp++; if (o.pe_en_m1 !== 1'b0 || o.pe_en_m2 !== 1'b1) begin
      n_bad++; $display("FAIL t2_pe_en: got M+1 %b M+2 %b want 0 1", o.pe_en_m1, o.pe_en_m2);
    end
  endtask

  task automatic test_backpressure();
    obs_t o;
    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] exp_wdata;
    scramble_clients();
    cli_we[4] = 1'b1;
    exp_addr  = addr_a[4];
    exp_wdata = wdata_a[4];
    run_txn(5'b10000, 5, 2, 64'h0123_4567_89AB_CDEF, 1'b1, 1'b0, o);
    n_cmp++; if (!o.hold_ok) begin n_bad++; $display("FAIL t3_hold: got unstable command want stable for 5 cycles"); end
    n_cmp++; if (o.addr !== exp_addr || o.wdata !== exp_wdata || o.we !== 1'b1) begin
      n_bad++; $display("FAIL t3_cmd: got %h/%h/%b want %h/%h/1", o.addr, o.wdata, o.we, exp_addr, exp_wdata);
    end
    n_cmp++; if (o.ack !== 5'b10000 || o.early_ack !== 5'd0) begin
      n_bad++; $display("FAIL t3_ack: got %b (early %b) want 10000", o.ack, o.early_ack);
    end
  endtask

  task automatic test_back_to_back();
    obs_t o;
    logic [4:0] req;
    logic [ADDR_W-1:0] a0, a3;
    int w;
    scramble_clients();
    a0  = addr_a[0];
    a3  = addr_a[3];
    req = 5'b01001;
    w   = model_winner(req);
    run_txn(5'b00001 << w, 1, 1, 64'h1111, 1'b0, 1'b0, o);
    req[w] = 1'b0;
    n_cmp++; if (o.addr !== a0 || o.ack !== 5'b00001) begin
      n_bad++; $display("FAIL t4_first: got addr %h ack %b want %h 00001", o.addr, o.ack, a0);
    end
    run_txn(5'b00001 << model_winner(req), 0, 0, 64'h2222, 1'b0, 1'b0, o);
    n_cmp++; if (o.wait_cycles != 0) begin n_bad++; $display("FAIL t4_turnaround: got %0d extra cycles want 0", o.wait_cycles); end
    n_cmp++; if (o.addr !== a3 || o.ack !== 5'b01000 || o.rdata !== 64'h2222) begin
      n_bad++; $display("FAIL t4_second: got addr %h ack %b rdata %h want %h 01000 2222", o.addr, o.ack, o.rdata, a3);
    end
  endtask

  task automatic test_illegal_grant();
    obs_t o;
    logic [ADDR_W-1:0] a1;
    scramble_clients();
    a1 = addr_a[1];
    err_model = 1'b1;
    run_txn(5'b01010, 1, 1, 64'h3333, 1'b0, 1'b0, o);
    n_cmp++; if (o.addr !== a1 || o.ack !== 5'b00010) begin
      n_bad++; $display("FAIL t5_winner: got addr %h ack %b want %h 00010", o.addr, o.ack, a1);
    end
    n_cmp++; if (o.err !== 1'b1) begin n_bad++; $display("FAIL t5_err_set: got %b want 1", o.err); end
    run_txn(5'b00100, 0, 1, 64'h4444, 1'b0, 1'b0, o);
    n_cmp++; if (o.err !== 1'b1) begin n_bad++; $display("FAIL t5_err_sticky: got %b want 1", o.err); end
  endtask

  task automatic test_reset_mid_op();
    int waited;
    waited = 0;
    while (pe_en !== 1'b1 && waited < 8) begin
      @(negedge clk);
      waited++;
    end
    n_cmp++; if (pe_en !== 1'b1) begin n_bad++; $display("FAIL t6_idle_wait: got pe_en %b want 1", pe_en); end
    pe_grant = 5'b00010;
    @(negedge clk);
    pe_grant     = 5'd0;
    mc_cmd_ready = 1'b1;
    @(negedge clk);
    mc_cmd_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    err_model = 1'b0;
    n_cmp++; if (mc_cmd_valid !== 1'b0 || mc_addr !== 25'd0 || pe_en !== 1'b0 || err_multi !== 1'b0) begin
      n_bad++; $display("FAIL t6_zeroed: got valid %b addr %h pe_en %b err %b want 0 0 0 0", mc_cmd_valid, mc_addr, pe_en, err_multi);
    end
    mc_done  = 1'b1;
    mc_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
    @(negedge clk);
    mc_done = 1'b0;
    n_cmp++; if (cli_ack !== 5'd0 || pe_en !== 1'b1) begin
      n_bad++; $display("FAIL t6_late_done: got ack %b pe_en %b want 00000 1", cli_ack, pe_en);
    end
    @(negedge clk);
    n_cmp++; if (cli_ack !== 5'd0 || cli_rdata !== 64'd0 || mc_cmd_valid !== 1'b0) begin
      n_bad++; $display("FAIL t6_idle: got ack %b rdata %h valid %b want 00000 0 0", cli_ack, cli_rdata, mc_cmd_valid);
    end
  endtask

  task automatic test_random();
    obs_t o;
    logic [4:0] g;
    logic [DATA_W-1:0] rd;
    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] exp_wdata;
    logic exp_we;
    int w;
    for (int t = 0; t < 40; t++) begin
      scramble_clients();
      g = 5'($urandom_range(1, 31));
      if ($urandom_range(0, 3) != 0) g = 5'b00001 << $urandom_range(0, 4);
      w = model_winner(g);
      exp_addr  = addr_a[w];
      exp_wdata = wdata_a[w];
      exp_we    = cli_we[w];
      if ($countones(g) > 1) err_model = 1'b1;
      rd = {$urandom, $urandom};
      run_txn(g, $urandom_range(0, 4), $urandom_range(0, 4), rd, 1'($urandom), 1'($urandom), o);
      n_cmp++; if (o.addr !== exp_addr || o.wdata !== exp_wdata || o.we !== exp_we) begin
        n_bad++; $display("FAIL rnd_cmd[%0d]: got %h/%h/%b want %h/%h/%b", t, o.addr, o.wdata, o.we, exp_addr, exp_wdata, exp_we);
      end
      n_cmp++; if (o.ack !== (5'b00001 << w) || o.early_ack !== 5'd0 || o.ack_after !== 5'd0) begin
        n_bad++; $display("FAIL rnd_ack[%0d]: got %b early %b after %b want %b", t, o.ack, o.early_ack, o.ack_after, 5'b00001 << w);
      end
      n_cmp++; if (o.rdata !== rd) begin n_bad++; $display("FAIL rnd_rdata[%0d]: got %h want %h", t, o.rdata, rd); end
      n_cmp++; if (!o.hold_ok || !o.valid_drop || o.timeout) begin
        n_bad++; $display("FAIL rnd_handshake[%0d]: got hold %b drop %b timeout %b want 1 1 0", t, o.hold_ok, o.valid_drop, o.timeout);
      end
      n_cmp++; if (o.err !== err_model || o.pe_en_m2 !== 1'b1) begin
        n_bad++; $display("FAIL rnd_err_pe[%0d]: got err %b pe_en %b want %b 1", t, o.err, o.pe_en_m2, err_model);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 5; i++) begin
      addr_a[i]  = 25'd0;
      wdata_a[i] = 64'd0;
    end
    test_reset();
    test_single_read();
    test_backpressure();
    test_back_to_back();
    test_illegal_grant();
    test_reset_mid_op();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion want finish before time limit");
    $fatal(1);
  end

endmodule
